// File: rtl/vram_frame_writer.sv
// -----------------------------------------------------------------------------
// vram_frame_writer
//
// Multi-channel sample-to-VRAM frame loader. A valid/ready sample stream (or an
// internal ramp pattern) is right-shifted, saturated to a bar height and written
// one VRAM word per sample, channel-major ({channel, index} addressing). Each
// frame load starts on a falling edge of the display vsync, which arrives
// asynchronously from the pixel clock domain.
//
// Optional feature (compile-time macro FRAME_CLEAR_EN):
//   defined   - every frame load first writes 0 to all addresses (CLEAR state),
//               then loads samples.
//   undefined - frame loads go straight to sample writes.
//
// Ports:
//   clock       in   system clock
//   reset_n     in   asynchronous reset, active low
//   vsync_in    in   display vsync, asynchronous, active low
//   mode        in   0 LIVE, 1 RAMP, 2/3 FREEZE; only sampled at frame start
//   scale_sh    in   right shift applied to each source value (used live)
//   in_data     in   input sample (unsigned)
//   in_valid    in   sample valid
//   in_ready    out  sample accepted when in_valid & in_ready
//   vram_we     out  VRAM write strobe
//   vram_addr   out  {channel, index}
//   vram_data   out  saturated bar height
//   busy        out  high while a frame load is in progress
//   frame_done  out  one-cycle pulse alongside the final write of a frame
//   overrun     out  one-cycle pulse when a frame start arrives mid-load
// -----------------------------------------------------------------------------
module vram_frame_writer #(
  parameter int NUM_CH     = 2,
  parameter int DEPTH_LOG2 = 9,
  parameter int IN_W       = 16,
  parameter int DATA_W     = 10,
  parameter int MAX_VAL    = 479,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 0,
  localparam int ADDR_W    = CH_W + DEPTH_LOG2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              vsync_in,
  input  logic [1:0]        mode,
  input  logic [3:0]        scale_sh,
  input  logic [IN_W-1:0]   in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              vram_we,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [DATA_W-1:0] vram_data,
  output logic              busy,
  output logic              frame_done,
  output logic              overrun
);

  localparam int TOTAL = NUM_CH * (2 ** DEPTH_LOG2);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);

  typedef enum logic [1:0] {
    MODE_LIVE  = 2'd0,
    MODE_RAMP  = 2'd1,
    MODE_FRZ_A = 2'd2,
    MODE_FRZ_B = 2'd3
  } mode_e;

`ifdef FRAME_CLEAR_EN
  typedef enum logic [1:0] {
    S_ARM   = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2,
    S_CLEAR = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    S_ARM   = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_e;
`endif

  // ---------------------------------------------------------------------------
  // vsync synchroniser and falling-edge detect.
  // The flops reset to 1 so that a reset never looks like a vsync fall.
  // ---------------------------------------------------------------------------
  logic vs_meta;
  logic vs_sync;
  logic vs_prev;
  logic fs;

  // NOTE: sequential state uses non-blocking (<=) assignments so every flop
  // samples the pre-edge value of its neighbours; blocking here would collapse
  // the synchroniser chain into a single flop.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vs_meta <= 1'b1;
      vs_sync <= 1'b1;
      vs_prev <= 1'b1;
    end else begin
      vs_meta <= vsync_in;
      vs_sync <= vs_meta;
      vs_prev <= vs_sync;
    end
  end

  // High for one cycle after the synchronised vsync has fallen; the FSM acts
  // on it at the third clock edge after the raw vsync fall.
  assign fs = vs_prev & ~vs_sync;

  // ---------------------------------------------------------------------------
  // Scale and saturate. The ceiling comparison is done at full input width so
  // large values never alias into small bar heights after truncation.
  // ---------------------------------------------------------------------------
  function automatic logic [DATA_W-1:0] saturate(input logic [IN_W-1:0] src,
                                                 input logic [3:0]      sh);
    logic [IN_W-1:0] v;
    v = src >> sh;
    if (v > IN_W'(MAX_VAL)) return DATA_W'(MAX_VAL);
    return v[DATA_W-1:0];
  endfunction

  state_e            state;
  mode_e             cur_mode;
  logic [ADDR_W-1:0] cnt;
  logic [IN_W-1:0]   ramp_src;
  logic [IN_W-1:0]   wr_src;
  logic              transfer;
  logic              wr_now;
  logic              last;

  // Ramp source is the per-channel sample index, zero-extended.
  assign ramp_src = IN_W'(cnt[DEPTH_LOG2-1:0]);
  assign wr_src   = (cur_mode == MODE_RAMP) ? ramp_src : in_data;
  assign transfer = in_valid & in_ready;
  // RAMP writes every cycle; LIVE writes only on an accepted sample.
  assign wr_now   = (cur_mode == MODE_RAMP) | transfer;
  assign last     = (cnt == LAST_ADDR);

  // ---------------------------------------------------------------------------
  // Frame FSM with registered outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_ARM;
      cur_mode   <= MODE_LIVE;
      cnt        <= '0;
      in_ready   <= 1'b0;
      vram_we    <= 1'b0;
      vram_addr  <= '0;
      vram_data  <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      // NOTE: pulse outputs get a default each cycle and are only raised by the
      // branch that needs them, so no path can leave a strobe stuck high.
      vram_we    <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;

      case (state)
        S_ARM: begin
          if (fs) begin
            cur_mode <= mode_e'(mode);
            cnt      <= '0;
            // FREEZE (mode[1] set) leaves the previous frame untouched.
            if (!mode[1]) begin
              busy <= 1'b1;
`ifdef FRAME_CLEAR_EN
              state    <= S_CLEAR;
              in_ready <= 1'b0;
`else
              state    <= S_WRITE;
              in_ready <= (mode_e'(mode) == MODE_LIVE);
`endif
            end
          end
        end

`ifdef FRAME_CLEAR_EN
        S_CLEAR: begin
          if (fs) overrun <= 1'b1;
          vram_we   <= 1'b1;
          vram_addr <= cnt;
          vram_data <= '0;
          if (last) begin
            cnt      <= '0;
            state    <= S_WRITE;
            in_ready <= (cur_mode == MODE_LIVE);
          end else begin
            cnt <= cnt + ADDR_W'(1);
          end
        end
`endif

        S_WRITE: begin
          // A frame start mid-load is flagged but does not disturb the load.
          if (fs) overrun <= 1'b1;
          if (wr_now) begin
            vram_we   <= 1'b1;
            vram_addr <= cnt;
            vram_data <= saturate(wr_src, scale_sh);
            if (last) begin
              // in_ready drops on the same edge that registers the final
              // sample, so no extra sample is ever accepted.
              cnt        <= '0;
              state      <= S_DONE;
              in_ready   <= 1'b0;
              busy       <= 1'b0;
              frame_done <= 1'b1;
            end else begin
              cnt <= cnt + ADDR_W'(1);
            end
          end
        end

        // One cycle for the final write to retire; a frame start landing here
        // is dropped without an overrun.
        S_DONE: state <= S_ARM;

        default: state <= S_ARM;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_frame_writer.sv
// -----------------------------------------------------------------------------
// tb_vram_frame_writer
//
// Self-checking bench for vram_frame_writer (NUM_CH=2, DEPTH_LOG2=3, IN_W=16,
// DATA_W=10, MAX_VAL=479). A monitor records every VRAM write; each test builds
// the expected write list from the frame rules (address order, min(src>>sh,
// MAX_VAL)) and compares. Builds with or without FRAME_CLEAR_EN.
// -----------------------------------------------------------------------------
module tb_vram_frame_writer;

  localparam int NUM_CH     = 2;
  localparam int DEPTH_LOG2 = 3;
  localparam int IN_W       = 16;
  localparam int DATA_W     = 10;
  localparam int MAX_VAL    = 479;
  localparam int ADDR_W     = 4;
  localparam int FRAME      = NUM_CH * (1 << DEPTH_LOG2);
`ifdef FRAME_CLEAR_EN
  localparam int CLEAR_N = FRAME;
`else
  localparam int CLEAR_N = 0;
`endif

  logic              clock = 1'b0;
  logic              reset_n = 1'b1;
  logic              vsync_in = 1'b1;
  logic [1:0]        mode = 2'd0;
  logic [3:0]        scale_sh = 4'd0;
  logic [IN_W-1:0]   in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              vram_we;
  logic [ADDR_W-1:0] vram_addr;
  logic [DATA_W-1:0] vram_data;
  logic              busy;
  logic              frame_done;
  logic              overrun;

  vram_frame_writer #(
    .NUM_CH    (NUM_CH),
    .DEPTH_LOG2(DEPTH_LOG2),
    .IN_W      (IN_W),
    .DATA_W    (DATA_W),
    .MAX_VAL   (MAX_VAL)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .vsync_in  (vsync_in),
    .mode      (mode),
    .scale_sh  (scale_sh),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .vram_we   (vram_we),
    .vram_addr (vram_addr),
    .vram_data (vram_data),
    .busy      (busy),
    .frame_done(frame_done),
    .overrun   (overrun)
  );

  always #5 clock = ~clock;

  typedef struct {
    int addr;
    int data;
    bit fd;
  } wr_t;

  wr_t obs[$];
  wr_t exp_q[$];
  int  data_arr[FRAME];
  int  n_cmp = 0;
  int  n_err = 0;
  int  n_fd  = 0;
  int  n_ovr = 0;

  // Monitor: outputs are sampled on the falling edge, away from the active edge.
  always @(negedge clock) begin
    if (vram_we) obs.push_back('{addr: int'(vram_addr), data: int'(vram_data), fd: frame_done});
    if (frame_done) n_fd++;
    if (overrun) n_ovr++;
  end

  // Reference: bar height is the shifted sample, capped at MAX_VAL.
  function automatic int sat_ref(input int src, input int sh);
    int v;
    v = src >> sh;
    return (v > MAX_VAL) ? MAX_VAL : v;
  endfunction

  // Expected write list for one frame: optional zero pass, then samples.
  function automatic void build_expected(input bit ramp, input int sh);
    exp_q.delete();
    for (int i = 0; i < CLEAR_N; i++) exp_q.push_back('{addr: i, data: 0, fd: 1'b0});
    for (int k = 0; k < FRAME; k++) begin
      int src;
      src = ramp ? (k % (1 << DEPTH_LOG2)) : data_arr[k];
      exp_q.push_back('{addr: k, data: sat_ref(src, sh), fd: (k == FRAME - 1)});
    end
  endfunction

  task automatic start_frame(input logic [1:0] m);
    @(negedge clock);
    mode     = m;
    vsync_in = 1'b0;
    repeat (4) @(negedge clock);
    vsync_in = 1'b1;
  endtask

  task automatic wait_writes(input int n, input int budget, output bit ok);
    int c;
    c = 0;
    while (obs.size() < n && c < budget) begin
      @(negedge clock);
      c++;
    end
    ok = (obs.size() >= n);
  endtask

  // Offers samples k0..n_xfer-1. vmode: 0 toggle, 1 always valid, 2 random.
  // A transfer is counted when valid is driven while in_ready is high; it
  // completes at the following rising edge.
  task automatic drive_live(input int n_xfer, input int vmode, input int k0, output bit ok);
    int  k;
    int  c;
    logic v;
    k = k0;
    c = 0;
    while (k < n_xfer && c < 400) begin
      @(negedge clock);
      c++;
      case (vmode)
        0:       v = (c % 2 == 1);
        1:       v = 1'b1;
        default: v = 1'(($urandom_range(0, 1)));
      endcase
      in_valid = v;
      in_data  = IN_W'(data_arr[k]);
      if (v && in_ready) k++;
    end
    ok = (k == n_xfer);
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (vram_we !== 1'b0) begin n_err++; $display("FAIL reset_vram_we: got %b want 0", vram_we); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    n_cmp++; if (vram_addr !== '0) begin n_err++; $display("FAIL reset_addr: got %0d want 0", vram_addr); end
    n_cmp++; if (vram_data !== '0) begin n_err++; $display("FAIL reset_data: got %0d want 0", vram_data); end
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    obs.delete();
    repeat (10) @(negedge clock);
    n_cmp++; if (obs.size() !== 0) begin n_err++; $display("FAIL idle_writes: got %0d want 0", obs.size()); end
  endtask

  task automatic test_ramp(input int sh);
    bit ok;
    scale_sh = 4'(sh);
    obs.delete();
    n_fd = 0;
    build_expected(1'b1, sh);
    start_frame(2'd1);
    wait_writes(exp_q.size(), 200, ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL ramp_timeout: got %0d writes want %0d", obs.size(), exp_q.size()); end
    repeat (30) @(negedge clock);
    n_cmp++; if (obs.size() !== exp_q.size()) begin n_err++; $display("FAIL ramp_count: got %0d want %0d", obs.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      n_cmp++;
      if (obs[i].addr !== exp_q[i].addr || obs[i].data !== exp_q[i].data || obs[i].fd !== exp_q[i].fd) begin
        n_err++;
        $display("FAIL ramp_sh%0d_w%0d: got a=%0d d=%0d fd=%0d want a=%0d d=%0d fd=%0d", sh, i,
                 obs[i].addr, obs[i].data, obs[i].fd, exp_q[i].addr, exp_q[i].data, exp_q[i].fd);
      end
    end
    n_cmp++; if (n_fd !== 1) begin n_err++; $display("FAIL ramp_frame_done_count: got %0d want 1", n_fd); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ramp_busy_after: got %b want 0", busy); end
  endtask

  // dkind: 0 -> 100*k, 1 -> 16'hFFFF, 2 -> random.
  task automatic test_live(input string name, input int dkind, input int vmode, input int sh);
    bit ok;
    for (int k = 0; k < FRAME; k++)
      data_arr[k] = (dkind == 0) ? 100 * k : (dkind == 1) ? 'hFFFF : int'($urandom_range(0, 65535));
    scale_sh = 4'(sh);
    in_valid = 1'b0;
    obs.delete();
    n_fd = 0;
    build_expected(1'b0, sh);
    start_frame(2'd0);
    drive_live(FRAME, vmode, 0, ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL %s_xfer_timeout: got %0d writes", name, obs.size()); end
    // Keep offering a sample: none may be accepted once the frame is full.
    in_valid = 1'b1;
    @(negedge clock);
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL %s_ready_after_last: got %b want 0", name, in_ready); end
    repeat (10) @(negedge clock);
    in_valid = 1'b0;
    n_cmp++; if (obs.size() !== exp_q.size()) begin n_err++; $display("FAIL %s_count: got %0d want %0d", name, obs.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      n_cmp++;
      if (obs[i].addr !== exp_q[i].addr || obs[i].data !== exp_q[i].data || obs[i].fd !== exp_q[i].fd) begin
        n_err++;
        $display("FAIL %s_w%0d: got a=%0d d=%0d fd=%0d want a=%0d d=%0d fd=%0d", name, i,
                 obs[i].addr, obs[i].data, obs[i].fd, exp_q[i].addr, exp_q[i].data, exp_q[i].fd);
      end
    end
    n_cmp++; if (n_fd !== 1) begin n_err++; $display("FAIL %s_frame_done_count: got %0d want 1", name, n_fd); end
  endtask

  task automatic test_freeze();
    bit active;
    active = 1'b0;
    obs.delete();
    start_frame(2'(2 + $urandom_range(0, 1)));
    in_valid = 1'b1;
    repeat (40) begin
      @(negedge clock);
      if (in_ready || busy) active = 1'b1;
    end
    in_valid = 1'b0;
    n_cmp++; if (active !== 1'b0) begin n_err++; $display("FAIL freeze_ready_busy: got %b want 0", active); end
    n_cmp++; if (obs.size() !== 0) begin n_err++; $display("FAIL freeze_writes: got %0d want 0", obs.size()); end
  endtask

  task automatic test_overrun();
    bit ok;
    for (int k = 0; k < FRAME; k++) data_arr[k] = int'($urandom_range(0, 2000));
    scale_sh = 4'd0;
    obs.delete();
    n_fd = 0;
    build_expected(1'b0, 0);
    start_frame(2'd0);
    drive_live(5, 1, 0, ok);
    @(negedge clock);
    in_valid = 1'b0;
    n_ovr = 0;
    // Second vsync fall mid-frame, with mode switched to RAMP, which must be ignored.
    start_frame(2'd1);
    repeat (4) @(negedge clock);
    n_cmp++; if (n_ovr !== 1) begin n_err++; $display("FAIL overrun_pulses: got %0d want 1", n_ovr); end
    n_cmp++; if (obs.size() !== CLEAR_N + 5) begin n_err++; $display("FAIL overrun_paused_writes: got %0d want %0d", obs.size(), CLEAR_N + 5); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL overrun_busy: got %b want 1", busy); end
    drive_live(FRAME, 1, 5, ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL overrun_resume_timeout: got %0d writes", obs.size()); end
    @(negedge clock);
    in_valid = 1'b0;
    repeat (10) @(negedge clock);
    n_cmp++; if (obs.size() !== exp_q.size()) begin n_err++; $display("FAIL overrun_count: got %0d want %0d", obs.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      n_cmp++;
      if (obs[i].addr !== exp_q[i].addr || obs[i].data !== exp_q[i].data || obs[i].fd !== exp_q[i].fd) begin
        n_err++;
        $display("FAIL overrun_w%0d: got a=%0d d=%0d fd=%0d want a=%0d d=%0d fd=%0d", i,
                 obs[i].addr, obs[i].data, obs[i].fd, exp_q[i].addr, exp_q[i].data, exp_q[i].fd);
      end
    end
    n_cmp++; if (n_fd !== 1) begin n_err++; $display("FAIL overrun_frame_done_count: got %0d want 1", n_fd); end
    mode = 2'd0;
  endtask

  task automatic test_reset_abort();
    bit ok;
    for (int k = 0; k < FRAME; k++) data_arr[k] = int'($urandom_range(0, 600));
    scale_sh = 4'd0;
    obs.delete();
    start_frame(2'd0);
    drive_live(7, 1, 0, ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL abort_xfer_timeout: got %0d writes", obs.size()); end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    n_cmp++; if (vram_we !== 1'b1) begin n_err++; $display("FAIL abort_7th_write: got we=%b want 1", vram_we); end
    reset_n = 1'b0;
    #1;
    n_cmp++; if (vram_we !== 1'b0) begin n_err++; $display("FAIL abort_async_we: got %b want 0", vram_we); end
    n_cmp++; if (busy !== 1'b0 || in_ready !== 1'b0) begin n_err++; $display("FAIL abort_busy_ready: got %b%b want 00", busy, in_ready); end
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    test_live("after_reset", 2, 1, 0);
  endtask

  initial begin
    test_reset();
    test_ramp(0);
    test_ramp(int'($urandom_range(1, 3)));
    test_live("live_100k", 0, 0, 0);
    test_live("sat_sh4", 1, 1, 4);
    test_live("sat_sh15", 1, 1, 15);
    test_live("live_rand", 2, 2, int'($urandom_range(0, 7)));
    test_freeze();
    test_overrun();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
